// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// Frame on tx_out, LSB first: start(0), WIDTH data bits, optional even parity, stop(1).
// Each bit is held for CLKS_PER_BIT clocks. Every output comes from a flop.
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_out,
    output logic             busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_n;
    logic [BW-1:0]    baud_q, baud_n;
    logic [CW-1:0]    bitc_q, bitc_n;
    logic [WIDTH-1:0] shift_q, shift_n;
    logic             par_q, par_n;
    logic             out_n;
    logic             ready_n;
    logic             bit_end;

    // State, counters, shifter and the registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bitc_q   <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_out   <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_n;
            baud_q   <= baud_n;
            bitc_q   <= bitc_n;
            shift_q  <= shift_n;
            par_q    <= par_n;
            tx_out   <= out_n;
            tx_ready <= ready_n;
            busy     <= ~ready_n;
        end
    end

    // Next-state logic; outputs are derived from the next state so the
    // line value appears in the same cycle the state is entered.
    always_comb begin
        state_n = state_q;
        baud_n  = baud_q;
        bitc_n  = bitc_q;
        shift_n = shift_q;
        par_n   = par_q;
        bit_end = (baud_q == BAUD_LAST);

        // Baud counter runs only inside a frame and wraps on every bit boundary.
        if (state_q != IDLE) begin
            baud_n = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shift_n = tx_data;
                    par_n   = ^tx_data;
                    baud_n  = '0;
                    bitc_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (bitc_q == BIT_LAST) begin
                        bitc_n  = '0;
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitc_n  = bitc_q + 1'b1;
                        shift_n = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                if (bit_end) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        case (state_n)
            START:   out_n = 1'b0;
            DATA:    out_n = shift_n[0];
            PARITY:  out_n = par_n;
            default: out_n = 1'b1;
        endcase

        ready_n = (state_n == IDLE);
    end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: table vectors, hand sequences for
// back-to-back, reset abort and CLKS_PER_BIT=1, then random words against
// a slot-based frame model.
module tb_serial_tx;

    localparam int W    = 8;
    localparam int CPB  = 4;
    localparam int PE   = 1;
    localparam int CPB2 = 1;
    localparam int PE2  = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0, tx_valid2 = 1'b0;
    logic [7:0] tx_data = '0, tx_data2 = '0;
    logic       tx_ready, tx_out, busy;
    logic       tx_ready2, tx_out2, busy2;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(PE)) dut (
        .clk(clk), .reset(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_out(tx_out), .busy(busy)
    );

    serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB2), .PARITY_EN(PE2)) dut2 (
        .clk(clk), .reset(rst_n), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .tx_data(tx_data2), .tx_out(tx_out2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc[$];

    // Record the cycle number of every accept edge on the main DUT.
    always @(posedge clk) begin
        if (tx_valid && tx_ready) acc.push_back(cyc);
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected line value i cycles after the accept edge: the frame is a list
    // of slots (start, data LSB first, optional parity, stop), each cpb long.
    function automatic logic model_bit(input logic [7:0] d, input int cpb, input int pe, input int i);
        int slot;
        slot = i / cpb;
        if (slot == 0) return 1'b0;
        if (slot <= W) return d[slot-1];
        if (pe != 0 && slot == W + 1) return (($countones(d) % 2) == 1);
        return 1'b1;
    endfunction

    // Wait (bounded) for ready, present one word, return just after the accept edge.
    task automatic send(input int sel, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (((sel == 0) ? tx_ready : tx_ready2) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready still low after %0d cycles", n);
        end
        if (sel == 0) begin tx_data = d; tx_valid = 1'b1; end
        else          begin tx_data2 = d; tx_valid2 = 1'b1; end
        @(posedge clk);
        #1;
        if (sel == 0) tx_valid = 1'b0;
        else          tx_valid2 = 1'b0;
    endtask

    // Check every cycle of a frame that was accepted at the previous edge,
    // then the first idle cycle after it.
    task automatic check_frame(input int sel, input logic [7:0] d, input string tag, output logic par_seen);
        int cpb, pe, f;
        logic o, r, b;
        cpb = (sel == 0) ? CPB : CPB2;
        pe  = (sel == 0) ? PE : PE2;
        f   = (2 + W + pe) * cpb;
        par_seen = 1'bx;
        for (int i = 0; i < f; i++) begin
            @(negedge clk);
            o = (sel == 0) ? tx_out : tx_out2;
            r = (sel == 0) ? tx_ready : tx_ready2;
            b = (sel == 0) ? busy : busy2;
            chk({tag, " tx_out"}, 32'(o), 32'(model_bit(d, cpb, pe, i)));
            chk({tag, " ready/busy"}, 32'({r, b}), 32'(2'b01));
            if (pe != 0 && i == (W + 1) * cpb) par_seen = o;
        end
        @(negedge clk);
        o = (sel == 0) ? tx_out : tx_out2;
        r = (sel == 0) ? tx_ready : tx_ready2;
        b = (sel == 0) ? busy : busy2;
        chk({tag, " idle after frame"}, 32'({o, r, b}), 32'(3'b110));
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic       p;
        logic [7:0] d;
        int         gap;

        tbl[0] = '{8'hA5, 1'b0};
        tbl[1] = '{8'h01, 1'b1};
        tbl[2] = '{8'h80, 1'b1};
        tbl[3] = '{8'hFF, 1'b0};
        tbl[4] = '{8'h3C, 1'b0};
        tbl[5] = '{8'hC3, 1'b0};
        tbl[6] = '{8'h07, 1'b1};
        tbl[7] = '{8'h5B, 1'b1};

        // Reset state, then 100 idle cycles with no valid.
        repeat (3) @(negedge clk);
        chk("reset state", 32'({tx_out, tx_ready, busy}), 32'(3'b110));
        chk("reset state dut2", 32'({tx_out2, tx_ready2, busy2}), 32'(3'b110));
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle no valid", 32'({tx_out, tx_ready, busy}), 32'(3'b110));
        end

        // Table vectors; tx_data is disturbed during START and must not leak in.
        for (int i = 0; i < 8; i++) begin
            send(0, tbl[i].data);
            tx_data = (i == 0) ? 8'h00 : ~tbl[i].data;
            check_frame(0, tbl[i].data, "table", p);
            chk("table parity bit", 32'(p), 32'(tbl[i].par));
        end

        // Back-to-back with tx_valid held: 0x01 then 0x80.
        @(negedge clk);
        tx_data = 8'h01;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = 8'h80;
        check_frame(0, 8'h01, "b2b first", p);
        chk("b2b first parity", 32'(p), 32'(1'b1));
        @(posedge clk);
        #1 tx_valid = 1'b0;
        tx_data = 8'h00;
        check_frame(0, 8'h80, "b2b second", p);
        chk("b2b second parity", 32'(p), 32'(1'b1));
        chk("b2b accept spacing", 32'(acc[acc.size()-1] - acc[acc.size()-2]), 32'd45);

        // Reset asserted during data bit 3 of 0x3C aborts at once.
        send(0, 8'h3C);
        repeat (17) @(negedge clk);
        chk("pre-abort bit3", 32'({tx_out, tx_ready, busy}), 32'(3'b101));
        #2 rst_n = 1'b0;
        #1 chk("async abort", 32'({tx_out, tx_ready, busy}), 32'(3'b110));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle after abort", 32'({tx_out, tx_ready, busy}), 32'(3'b110));
        end
        send(0, 8'hC3);
        check_frame(0, 8'hC3, "after abort", p);

        // CLKS_PER_BIT=1, no parity.
        send(1, 8'hFF);
        check_frame(1, 8'hFF, "cpb1 FF", p);
        send(1, 8'h5A);
        tx_data2 = 8'hFF;
        check_frame(1, 8'h5A, "cpb1 5A", p);

        // Random words with random idle gaps.
        for (int n = 0; n < 25; n++) begin
            d   = 8'($urandom);
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(negedge clk);
                chk("random gap idle", 32'({tx_out, tx_ready, busy}), 32'(3'b110));
            end
            send(0, d);
            tx_data = 8'($urandom);
            check_frame(0, d, "random", p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_tx.md
Name:
serial_tx

Overview:
- Serializing transmitter that drives the 1-bit `data` line consumed by the existing serial-input sequential blocks.
- Accepts a parallel word over a valid/ready handshake.
- Emits a frame on `tx_out`, least significant bit first: start bit, WIDTH data bits, optional even-parity bit, stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- Serves as the stimulus-side counterpart in FSM and constant-driver analysis vectors: it contains a real FSM, counters and registers reset to constants.

Parameters:
- WIDTH, 8, data bits per frame (≥1).
- CLKS_PER_BIT, 4, clock cycles each bit is held (≥1).
- PARITY_EN, 1, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word.
- tx_data  input  WIDTH  word to send.
- tx_out  output  1  serial line; idles high.
- busy  output  1  frame in progress; equals ~tx_ready.

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous and active-low.
- Reset values: tx_out=1, tx_ready=1, busy=0, state=IDLE, bit and baud counters=0, shift register=0.
  - Reset asserted mid-frame aborts immediately: tx_out=1 with no partial stop bit.
  - The first accept after release follows normal rules.
- Outputs: all outputs are registered, with no combinational path from any input to any output.
- Derived frame length: P = PARITY_EN. Frame F = (2 + WIDTH + P) * CLKS_PER_BIT cycles.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_ready=1, tx_out=1.
  - Accept when tx_valid && tx_ready at a rising edge: latch tx_data into the shift register, compute parity = XOR of the bits, go to START.
- START:
  - tx_out=0 for CLKS_PER_BIT cycles, beginning the cycle after the accept edge.
  - Then go to DATA.
- DATA:
  - tx_out = shift[0]; shift right once per bit period.
  - The bit counter counts 0..WIDTH-1.
  - After bit WIDTH-1, go to PARITY if PARITY_EN, else go to STOP.
- PARITY: tx_out = latched even-parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Width is max(1, $clog2(CLKS_PER_BIT)).
  - With CLKS_PER_BIT=1 every state lasts exactly one cycle.
- tx_ready / busy:
  - tx_ready deasserts the cycle after accept and stays low for exactly F cycles.
  - It reasserts on the first IDLE cycle after the stop bit.
  - Minimum spacing between consecutive accept edges is F+1 cycles.
- Input handling:
  - tx_data and tx_valid are ignored while tx_ready=0. Changes to tx_data mid-frame do not affect the frame.
  - tx_valid held high continuously yields back-to-back frames separated by one idle-high cycle.
  - tx_valid low in IDLE: line stays high indefinitely.
- Parity: even parity over the data bits only, so the count of ones in data plus parity is even.

Test Plan:
- Reset release, no valid → tx_out=1, tx_ready=1, busy=0 for 100 cycles.
- WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=1, send 0xA5 → 44-cycle frame: 0 start, data bits 1,0,1,0,0,1,0,1, parity 0, stop 1, each held 4 cycles; tx_ready low exactly 44 cycles.
- Same config, send 0x01 then 0x80 with tx_valid held high → parity bit 1 in both frames; second accept exactly 45 cycles after the first; one idle-high cycle between frames.
- CLKS_PER_BIT=1, PARITY_EN=0, send 0xFF → tx_out sequence 0,1,1,1,1,1,1,1,1,1 over 10 cycles, then IDLE.
- Assert reset (low) during data bit 3 of 0x3C → tx_out=1 and tx_ready=1 asynchronously; after release, sending 0xC3 produces a clean full frame.
- Change tx_data from 0xA5 to 0x00 during START → transmitted bits still encode 0xA5.
